uart_rx_param: RTL and testbench

Parametrised UART receiver and successor to the fixed 8N1 `RxD` receiver. Supports:
- 5–9 data bits, optional even/odd parity, 1 or 2 stop bits;
- 3-sample majority voting, start-bit glitch rejection and break handling;
- a small output FIFO with valid/ready handshake and per-byte error flags.

It sits between the `rx_pin` pad and the packet parser.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_rx_param_if.sv | 41 ++++
 rtl/uart_sync_fifo.sv | 85 ++++++++
 rtl/uart_rx_param.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and helpers for the parametrised UART receiver.
//             parity_t   - parity mode selector (none / even / odd)
//             rx_state_t - receiver frame FSM states
//             clog2      - ceiling log2 usable in constant expressions
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } rx_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_param_if
//  Purpose  : Consumer-side handshake bundle of the UART receiver.
//  Signals  : rx_data       head-of-FIFO data word
//             rx_frame_err  head word had a bad stop bit
//             rx_parity_err head word failed parity
//             rx_valid      FIFO not empty
//             rx_ready      consumer accepts head when rx_valid & rx_ready
//             overrun       one-cycle pulse when a completed word was dropped
//             fifo_count    FIFO occupancy
//  Modports : master - receiver side, slave - consumer side
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_param_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 overrun;
    logic [CW-1:0]        fifo_count;

    modport master (
        output rx_data, rx_frame_err, rx_parity_err, rx_valid, overrun, fifo_count,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_frame_err, rx_parity_err, rx_valid, overrun, fifo_count,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync_fifo
//  Purpose  : Small single-clock FIFO with first-word fall-through head.
//  Ports    : clk, reset (async, active-high)
//             push / push_data  write request and word
//             pop               advance head (ignored when empty)
//             head              current head word, 0 when empty
//             valid             FIFO not empty (registered)
//             count             occupancy (registered)
//             overrun           pulse: push arrived on a full FIFO and was dropped
//  Revision : 1.0  initial release
// ============================================================================
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] head,
    output logic                  valid,
    output logic      [CW-1:0]    count,
    output logic                  overrun
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    logic full;
    logic do_pop;
    logic do_push;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);

    // Gating with valid keeps the head at zero after reset and when drained.
    assign head = valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= push & ~do_push;
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10: begin
                    count <= count + 1'b1;
                    valid <= 1'b1;
                end
                2'b01: begin
                    count <= count - 1'b1;
                    valid <= (count != CW'(1));
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_param
//  Purpose  : Parametrised UART receiver (5-9 data bits, none/even/odd parity,
//             1 or 2 stop bits) with 3-sample majority voting, start-bit
//             glitch rejection, break handling and an output FIFO.
//  Ports    : clk     sole clock
//             reset   asynchronous, active-high
//             rx_pin  serial line, idle high, asynchronous to clk
//             bus     consumer handshake (uart_rx_param_if.master)
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 86,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic rx_pin,
    uart_rx_param_if.master bus
);

    localparam int      H        = CLK_PER_BIT / 2;
    localparam int      CNT_W    = clog2(CLK_PER_BIT);
    localparam int      WIDTH    = DATA_BITS + 2;
    localparam parity_t PAR_MODE = (PARITY == 2) ? PAR_ODD :
                                   (PARITY == 1) ? PAR_EVEN : PAR_NONE;

    // ------------------------------------------------------------------
    // Synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic sync1;
    logic rx_s;
    logic rx_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_pin;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    logic fall;
    assign fall = rx_prev & ~rx_s;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    rx_state_t            state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic                 samp0;
    logic                 samp1;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 frm_err;
    logic                 push;
    logic [WIDTH-1:0]     push_word;

    logic at_s0;
    logic at_s1;
    logic at_dec;
    logic at_end;
    logic vote;
    logic frm_next;
    logic last_data;
    logic last_stop;

    assign at_s0     = (bit_cnt == CNT_W'(H - 1));
    assign at_s1     = (bit_cnt == CNT_W'(H));
    assign at_dec    = (bit_cnt == CNT_W'(H + 1));
    assign at_end    = (bit_cnt == CNT_W'(CLK_PER_BIT - 1));
    // Third sample is the live synchronised line at the decision cycle.
    assign vote      = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
    assign frm_next  = frm_err | ~vote;
    assign last_data = (bit_idx == 4'(DATA_BITS - 1));
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            samp0     <= 1'b1;
            samp1     <= 1'b1;
            shreg     <= '0;
            par_err   <= 1'b0;
            frm_err   <= 1'b0;
            push      <= 1'b0;
            push_word <= '0;
        end else begin
            push <= 1'b0;

            // Bit-slot timer runs only while a frame is being sampled.
            if (state != S_IDLE && state != S_WAIT_HIGH) begin
                bit_cnt <= at_end ? '0 : bit_cnt + 1'b1;
                if (at_s0) samp0 <= rx_s;
                if (at_s1) samp1 <= rx_s;
            end

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        par_err  <= 1'b0;
                        frm_err  <= 1'b0;
                        state    <= S_START;
                    end
                end

                S_START: begin
                    if (at_dec && vote) begin
                        state <= S_IDLE;        // too short to be a start bit
                    end else if (at_end) begin
                        state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (at_dec) begin
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                    end
                    if (at_end) begin
                        if (last_data) begin
                            state <= (PAR_MODE != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

                S_PARITY: begin
                    if (at_dec) begin
                        par_err <= (PAR_MODE == PAR_ODD) ? (vote == ^shreg)
                                                         : (vote != ^shreg);
                    end
                    if (at_end) begin
                        state <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (at_dec) begin
                        frm_err <= frm_next;
                        if (last_stop) begin
                            // Push at the decision so a back-to-back start
                            // bit right after this stop bit is not missed.
                            push      <= 1'b1;
                            push_word <= {par_err, frm_next, shreg};
                            state     <= frm_next ? S_WAIT_HIGH : S_IDLE;
                        end
                    end else if (at_end) begin
                        stop_idx <= 1'b1;
                    end
                end

                S_WAIT_HIGH: begin
                    // A held-low line (break) must return high before a new
                    // start edge can be recognised.
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] head;

    uart_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (bus.rx_ready),
        .head      (head),
        .valid     (bus.rx_valid),
        .count     (bus.fifo_count),
        .overrun   (bus.overrun)
    );

    assign bus.rx_data       = head[DATA_BITS-1:0];
    assign bus.rx_frame_err  = head[DATA_BITS];
    assign bus.rx_parity_err = head[DATA_BITS+1];

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_param
//  Purpose  : Self-checking bench for uart_rx_param. Two receivers share the
//             clock and reset: dut_a is 8N1, dut_p is 8E1. Expected words
//             {parity_err, frame_err, data} are queued when a frame is sent
//             and popped when the receiver presents a word.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int CPB   = 86;
    localparam int BIT_T = CPB * 10;   // 10-unit clock period

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx_a  = 1'b1;
    logic rx_p  = 1'b1;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_a ();
    uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_p ();

    uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .rx_pin(rx_a), .bus(bus_a));

    uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
        .clk(clk), .reset(reset), .rx_pin(rx_p), .bus(bus_p));

    int         n_cmp = 0;
    int         n_bad = 0;
    int         ovr_cycles = 0;
    logic [9:0] exp_q [$];

    always @(negedge clk) begin
        if (bus_a.overrun === 1'b1) ovr_cycles = ovr_cycles + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] pop_exp();
        if (exp_q.size() == 0) return 10'bx;
        return exp_q.pop_front();
    endfunction

    function automatic logic [15:0] frame8(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    task automatic send_bits(input bit sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel) rx_p = bits[i];
            else     rx_a = bits[i];
            #(BIT_T);
        end
    endtask

    task automatic wait_valid(input bit sel, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((sel ? bus_p.rx_valid : bus_a.rx_valid) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_a.rx_ready = 1'b1;
        bus_p.rx_ready = 1'b1;
        #1000;
        @(negedge clk);
        n_cmp++; if (bus_a.rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", bus_a.rx_data); end
        n_cmp++; if (bus_a.rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_fe: got %b expected 0", bus_a.rx_frame_err); end
        n_cmp++; if (bus_a.rx_parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_pe: got %b expected 0", bus_a.rx_parity_err); end
        n_cmp++; if (bus_a.rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus_a.rx_valid); end
        n_cmp++; if (bus_a.overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", bus_a.overrun); end
        n_cmp++; if (bus_a.fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", bus_a.fifo_count); end
        n_cmp++;
        if ({bus_p.rx_data, bus_p.rx_frame_err, bus_p.rx_parity_err, bus_p.rx_valid,
             bus_p.overrun, bus_p.fifo_count} !== 15'd0) begin
            n_bad++; $display("FAIL reset_par_dut: got data=%h valid=%b count=%0d expected all 0",
                              bus_p.rx_data, bus_p.rx_valid, bus_p.fifo_count);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        bit got;
        logic [9:0] e;
        exp_q.push_back({2'b00, 8'hBB});
        fork
            send_bits(1'b0, frame8(8'hBB), 10);
            begin
                wait_valid(1'b0, 1500, got);
                e = pop_exp();
                n_cmp++;
                if (!got) begin n_bad++; $display("FAIL basic_word: got no rx_valid expected %h", e); end
                else if ({bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_data} !== e) begin
                    n_bad++; $display("FAIL basic_word: got %h expected %h",
                                      {bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_data}, e);
                end
                @(negedge clk);
                n_cmp++; if (bus_a.rx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_single_pulse: got valid %b expected 0", bus_a.rx_valid); end
            end
        join
    endtask

    task automatic test_parity();
        bit got;
        logic [9:0] e;
        logic p;
        for (int k = 0; k < 2; k++) begin
            p = k[0];
            // 0xA5 has four ones, so parity bit 0 is correct even parity.
            exp_q.push_back({p, 1'b0, 8'hA5});
            fork
                send_bits(1'b1, {5'b0, 1'b1, p, 8'hA5, 1'b0}, 11);
                begin
                    wait_valid(1'b1, 1600, got);
                    e = pop_exp();
                    n_cmp++;
                    if (!got) begin n_bad++; $display("FAIL parity_word_%0d: got no rx_valid expected %h", k, e); end
                    else if ({bus_p.rx_parity_err, bus_p.rx_frame_err, bus_p.rx_data} !== e) begin
                        n_bad++; $display("FAIL parity_word_%0d: got %h expected %h", k,
                                          {bus_p.rx_parity_err, bus_p.rx_frame_err, bus_p.rx_data}, e);
                    end
                end
            join
        end
    endtask

    task automatic test_glitch();
        bit got;
        logic [9:0] e;
        int seen;
        seen = 0;
        rx_a = 1'b0;
        #300;
        rx_a = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (bus_a.rx_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL glitch_no_push: got %0d valid cycles expected 0", seen); end
        n_cmp++; if (bus_a.fifo_count !== 3'd0) begin n_bad++; $display("FAIL glitch_count: got %0d expected 0", bus_a.fifo_count); end
        exp_q.push_back({2'b00, 8'h3C});
        fork
            send_bits(1'b0, frame8(8'h3C), 10);
            begin
                wait_valid(1'b0, 1500, got);
                e = pop_exp();
                n_cmp++;
                if (!got) begin n_bad++; $display("FAIL glitch_next_word: got no rx_valid expected %h", e); end
                else if ({bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_data} !== e) begin
                    n_bad++; $display("FAIL glitch_next_word: got %h expected %h",
                                      {bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_data}, e);
                end
            end
        join
    endtask

    task automatic test_break();
        bit got;
        logic [9:0] e;
        int seen;
        exp_q.push_back({2'b01, 8'h00});
        fork
            begin
                rx_a = 1'b0;
                #(20 * BIT_T);
                rx_a = 1'b1;
            end
            begin
                wait_valid(1'b0, 20 * CPB + 300, got);
                e = pop_exp();
                n_cmp++;
                if (!got) begin n_bad++; $display("FAIL break_word: got no rx_valid expected %h", e); end
                else if ({bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_data} !== e) begin
                    n_bad++; $display("FAIL break_word: got %h expected %h",
                                      {bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_data}, e);
                end
                @(negedge clk);
                seen = 0;
            end
        join
        // Anything beyond the single word would show up as further valid cycles.
        repeat (3 * CPB) begin
            @(negedge clk);
            if (bus_a.rx_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL break_single_word: got %0d extra valid cycles expected 0", seen); end
        exp_q.push_back({2'b00, 8'h55});
        fork
            send_bits(1'b0, frame8(8'h55), 10);
            begin
                wait_valid(1'b0, 1500, got);
                e = pop_exp();
                n_cmp++;
                if (!got) begin n_bad++; $display("FAIL break_next_word: got no rx_valid expected %h", e); end
                else if ({bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_data} !== e) begin
                    n_bad++; $display("FAIL break_next_word: got %h expected %h",
                                      {bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_data}, e);
                end
            end
        join
    endtask

    task automatic test_overrun();
        logic [9:0] e;
        logic [7:0] v;
        bus_a.rx_ready = 1'b0;
        @(negedge clk);
        ovr_cycles = 0;
        for (int i = 1; i <= 5; i++) begin
            v = 8'(i);
            if (i <= 4) exp_q.push_back({2'b00, v});
            send_bits(1'b0, frame8(v), 10);
        end
        repeat (200) @(negedge clk);
        n_cmp++; if (bus_a.fifo_count !== 3'd4) begin n_bad++; $display("FAIL overrun_count: got %0d expected 4", bus_a.fifo_count); end
        n_cmp++; if (ovr_cycles != 1) begin n_bad++; $display("FAIL overrun_pulse: got %0d cycles expected 1", ovr_cycles); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = pop_exp();
            n_cmp++;
            if (bus_a.rx_valid !== 1'b1 ||
                {bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_data} !== e) begin
                n_bad++; $display("FAIL overrun_drain_%0d: got valid=%b word=%h expected valid=1 word=%h",
                                  i, bus_a.rx_valid, {bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_data}, e);
            end
            bus_a.rx_ready = 1'b1;
            @(negedge clk);
            bus_a.rx_ready = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (bus_a.rx_valid !== 1'b0) begin n_bad++; $display("FAIL overrun_empty_valid: got %b expected 0", bus_a.rx_valid); end
        n_cmp++; if (bus_a.fifo_count !== 3'd0) begin n_bad++; $display("FAIL overrun_empty_count: got %0d expected 0", bus_a.fifo_count); end
        bus_a.rx_ready = 1'b1;
    endtask

    task automatic test_reset_midframe();
        bit got;
        logic [9:0] e;
        // Park one word in the FIFO so the reset has something to flush.
        bus_a.rx_ready = 1'b0;
        send_bits(1'b0, frame8(8'h42), 10);
        repeat (20) @(negedge clk);
        n_cmp++; if (bus_a.fifo_count !== 3'd1) begin n_bad++; $display("FAIL rstmid_preload: got %0d expected 1", bus_a.fifo_count); end
        fork
            send_bits(1'b0, frame8(8'hF0), 10);
            begin
                #(5 * BIT_T + BIT_T / 2);   // middle of data bit 4
                reset = 1'b1;
                #20;
                n_cmp++;
                if ({bus_a.rx_data, bus_a.rx_frame_err, bus_a.rx_parity_err, bus_a.rx_valid,
                     bus_a.overrun, bus_a.fifo_count} !== 15'd0) begin
                    n_bad++; $display("FAIL rstmid_outputs: got data=%h valid=%b count=%0d expected all 0",
                                      bus_a.rx_data, bus_a.rx_valid, bus_a.fifo_count);
                end
                #200;
                reset = 1'b0;
            end
        join
        bus_a.rx_ready = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_cmp++; if (bus_a.fifo_count !== 3'd0) begin n_bad++; $display("FAIL rstmid_discard: got %0d expected 0", bus_a.fifo_count); end
        exp_q.push_back({2'b00, 8'h81});
        fork
            send_bits(1'b0, frame8(8'h81), 10);
            begin
                wait_valid(1'b0, 1500, got);
                e = pop_exp();
                n_cmp++;
                if (!got) begin n_bad++; $display("FAIL rstmid_next_word: got no rx_valid expected %h", e); end
                else if ({bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_data} !== e) begin
                    n_bad++; $display("FAIL rstmid_next_word: got %h expected %h",
                                      {bus_a.rx_parity_err, bus_a.rx_frame_err, bus_a.rx_data}, e);
                end
            end
        join
        repeat (50) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drained: got %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
